// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (long-press event logic).
package button_debounce_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } btn_state_e;

  // Default cycle counts for a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_10MS_100MHZ = 32'd1_000_000;
  localparam int unsigned LONG_1S_100MHZ       = 32'd100_000_000;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM, registered
// level/press/release outputs and, when BUTTON_DEBOUNCE_LONG_PRESS_EN is
// defined, a saturating hold counter that emits a single long-press pulse.
module button_debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_CYCLES     = LONG_1S_100MHZ
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic but_n_i,
  output logic down_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned      DEB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 32'd1);

  logic [1:0]       sync_q;
  logic             pin_n_s;
  btn_state_e       state_q,   state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             down_q,    down_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  // Synchronise the raw pin; reset to 1 so the button reads as released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], but_n_i};
    end
  end

  assign pin_n_s = sync_q[1];

  // Debounce state, counter and registered level/edge outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RELEASED;
      deb_cnt_q <= '0;
      down_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      down_q    <= down_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive stable samples; any reversal falls back and restarts.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    down_d    = down_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!pin_n_s) begin
          state_d   = PRESS_PENDING;
          deb_cnt_d = '0;
        end else begin
          state_d   = RELEASED;
        end
      end
      PRESS_PENDING: begin
        if (pin_n_s) begin
          state_d = RELEASED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          down_d  = 1'b1;
          press_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (pin_n_s) begin
          state_d   = RELEASE_PENDING;
          deb_cnt_d = '0;
        end else begin
          state_d   = PRESSED;
        end
      end
      RELEASE_PENDING: begin
        if (!pin_n_s) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = RELEASED;
          down_d    = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d   = RELEASED;
        deb_cnt_d = '0;
        down_d    = 1'b0;
      end
    endcase
  end

  assign down_o    = down_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = cnt_width(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);

  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              long_q,      long_d;

  // Hold counter and one-shot long-press event register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // press_d marks the entry into PRESSED, which restarts the hold timing;
  // the counter then saturates at its last value and fires exactly once.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (press_d) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if ((state_q == PRESSED) || (state_q == RELEASE_PENDING)) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        long_d      = 1'b0;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  assign long_o = long_q;
`else
  // LONG_CYCLES has no effect in this build; it stays in the parameter list
  // so both builds share one interface.
  logic long_cfg_unused_s;
  assign long_cfg_unused_s = ^LONG_CYCLES;
  assign long_o            = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioning: NUM_BUTTONS independent debounce channels that
// turn active-low asynchronous pins into a clean active-high level plus
// single-cycle press/release/long-press events.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (BTN_LONG events;
// when undefined BTN_LONG is tied to 0).
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_CYCLES     = LONG_1S_100MHZ
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_BUTTONS-1:0] BUT,
  output logic [NUM_BUTTONS-1:0] BTN_DOWN,
  output logic [NUM_BUTTONS-1:0] BTN_PRESS,
  output logic [NUM_BUTTONS-1:0] BTN_RELEASE,
  output logic [NUM_BUTTONS-1:0] BTN_LONG
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk_i     (CLK),
      .rst_i     (RST),
      .but_n_i   (BUT[g]),
      .down_o    (BTN_DOWN[g]),
      .press_o   (BTN_PRESS[g]),
      .release_o (BTN_RELEASE[g]),
      .long_o    (BTN_LONG[g])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (DEBOUNCE_CYCLES=4,
// LONG_CYCLES=16, two channels). Expected output vectors are derived from
// the documented latencies (level change D+2 edges after the pin change,
// long press 16 edges after the level rises) and queued per cycle.
module tb_button_debounce;

  localparam int unsigned NB = 2;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NB-1:0] BUT = 2'b11;
  logic [NB-1:0] BTN_DOWN, BTN_PRESS, BTN_RELEASE, BTN_LONG;

  typedef struct packed {
    logic [1:0] down;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  button_debounce #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BUT         (BUT),
    .BTN_DOWN    (BTN_DOWN),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .BTN_LONG    (BTN_LONG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, then compare
  // after the active edge.
  task automatic cyc(input logic rst, input logic [1:0] but,
                     input logic [1:0] d, input logic [1:0] p,
                     input logic [1:0] r, input logic [1:0] l);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    BUT = but;
    e = '{down: d, press: p, rel: r, lng: l};
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("BTN_DOWN",    BTN_DOWN,    e.down);
    chk("BTN_PRESS",   BTN_PRESS,   e.press);
    chk("BTN_RELEASE", BTN_RELEASE, e.rel);
    chk("BTN_LONG",    BTN_LONG,    e.lng);
  endtask

  function automatic logic [1:0] b0(input bit c);
    return c ? 2'b01 : 2'b00;
  endfunction

  initial begin
    // Reset for two cycles, then idle: everything stays 0.
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) cyc(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

    // Clean press on channel 0 held 60 cycles: level at +6, long at +22.
    for (int i = 0; i < 60; i++)
      cyc(1'b0, 2'b10, b0(i >= 6), b0(i == 6), 2'b00, b0(LONG_EN && (i == 22)));

    // Glitch of 3 cycles on channel 1 while channel 0 stays held.
    for (int i = 0; i < 11; i++)
      cyc(1'b0, (i < 3) ? 2'b00 : 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);

    // Bouncy release of channel 0: 1,1,0 then steady 1 from step k=0.
    cyc(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 12; k++)
      cyc(1'b0, 2'b11, b0(k < 6), 2'b00, b0(k == 6), 2'b00);

    // Press again, then reset while held: no release event.
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 2'b10, b0(i >= 6), b0(i == 6), 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);

    // Still held after reset: fresh press 6 edges after the first sample,
    // and the long-press timing restarts from the new level rise.
    for (int i = 0; i < 30; i++)
      cyc(1'b0, 2'b10, b0(i >= 6), b0(i == 6), 2'b00, b0(LONG_EN && (i == 22)));

    // Clean release and idle tail.
    for (int k = 0; k < 10; k++)
      cyc(1'b0, 2'b11, b0(k < 6), 2'b00, b0(k == 6), 2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input conditioning stage between the board push-buttons and the LED/user logic. It synchronises the raw active-low `BUT` pins into the 100 MHz `CLK` domain and debounces them with a per-button counter FSM. It presents a clean active-high held level plus single-cycle press, release and (optional) long-press events. Downstream logic drives LEDs directly from `BTN_DOWN` with no further inversion.

## Interface
- `NUM_BUTTONS`, 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000: stable-input cycles required to accept a change (10 ms at 100 MHz); must be ≥ 1.
- `LONG_CYCLES`, 100_000_000: held cycles after press acceptance before the long-press event (1 s); must be ≥ 1.
- `CLK`  in  1: system clock, 100 MHz. Sole clock.
- `RST`  in  1: reset, synchronous, active-high.
- `BUT`  in  NUM_BUTTONS: raw button pins, active-low (0 = pushed), asynchronous.
- `BTN_DOWN`  out  NUM_BUTTONS: debounced level, 1 = held.
- `BTN_PRESS`  out  NUM_BUTTONS: 1-cycle pulse on the rising edge of `BTN_DOWN`.
- `BTN_RELEASE`  out  NUM_BUTTONS: 1-cycle pulse on the falling edge of `BTN_DOWN`.
- `BTN_LONG`  out  NUM_BUTTONS: 1-cycle pulse when held `LONG_CYCLES` cycles.

## Operation
- The channels are fully independent. All outputs are registered.
- Synchroniser: two flops per bit with reset value 1 (released). The FSM sees only the second flop, `s`.
- FSM states: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
  - RELEASED, `s`=0: go to PRESS_PENDING, deb_cnt←0.
  - PRESS_PENDING, `s`=1: go to RELEASED. The glitch is rejected and no output changes.
  - PRESS_PENDING, `s`=0 and deb_cnt == DEBOUNCE_CYCLES−1: go to PRESSED, `BTN_DOWN`←1, `BTN_PRESS` pulses, hold_cnt←0. Otherwise deb_cnt++.
  - PRESSED, `s`=1: go to RELEASE_PENDING, deb_cnt←0.
  - RELEASE_PENDING, `s`=0: return to PRESSED. hold_cnt keeps running.
  - RELEASE_PENDING, `s`=1 and deb_cnt == DEBOUNCE_CYCLES−1: go to RELEASED, `BTN_DOWN`←0, `BTN_RELEASE` pulses. Otherwise deb_cnt++.
- Long press:
  - hold_cnt increments in PRESSED and RELEASE_PENDING.
  - `BTN_LONG` pulses once when hold_cnt reaches LONG_CYCLES−1, then hold_cnt saturates.
  - hold_cnt clears on entry to PRESSED from PRESS_PENDING.
- Counter widths: `$clog2` of the respective parameter, minimum 1 bit. Counters never wrap.

## Timing
- Reset values:
  - `BTN_DOWN`, `BTN_PRESS`, `BTN_RELEASE`, `BTN_LONG` = 0.
  - Synchronisers = 1.
  - State = RELEASED.
  - Counters = 0.
- Press latency: for a pin held low from edge e0, `BTN_DOWN` and `BTN_PRESS` update at edge e0+DEBOUNCE_CYCLES+2. Release latency is the same, measured from the first edge sampling the pin high.
- `BTN_LONG` occurs LONG_CYCLES edges after `BTN_DOWN` rises.
- `BTN_PRESS`, `BTN_RELEASE` and `BTN_LONG` are never high for more than 1 cycle. `BTN_PRESS` and `BTN_RELEASE` are never high together on a channel.
- Any pin reversal during a PENDING state restarts acceptance. A pulse train shorter than DEBOUNCE_CYCLES never changes the outputs.
- Reset mid-operation:
  - All outputs read 0 after the `RST` edge. No `BTN_RELEASE` is generated.
  - If the button is still held after `RST` deasserts, a full press latency follows, then a new `BTN_PRESS`.

## Configuration
- `BUTTON_DEBOUNCE_LONG_PRESS_EN` defined: hold_cnt and the `BTN_LONG` logic are compiled in as described above.
- Not defined: no hold counter is synthesised, `BTN_LONG` is tied to 0, and `LONG_CYCLES` is ignored. All other behaviour is identical.

## Structure
- `button_debounce_pkg` contains:
  - The state enum typedef: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
  - Default cycle constants: DEBOUNCE_10MS_100MHZ and LONG_1S_100MHZ.
- Sub-module `button_debounce_channel`: synchroniser, FSM and counters for one bit. The top generates NUM_BUTTONS instances.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=16, NUM_BUTTONS=2.
- Reset: `RST`=1 for 2 cycles, `BUT`=2'b11 → all outputs 0, and they stay 0 for 20 idle cycles.
- Clean press: `BUT[0]`=0 from edge e0 → `BTN_DOWN[0]` rises at e0+6 with a 1-cycle `BTN_PRESS[0]` at e0+6. Channel 1 stays all 0.
- Glitch reject: `BUT[1]`=0 for 3 cycles, then 1 → no output change on either channel.
- Bouncy release: from held, `BUT[0]` goes 1 for 2 cycles, 0 for 1 cycle, then 1 steady from edge e1 → `BTN_DOWN[0]` falls at e1+6 with exactly one `BTN_RELEASE[0]` pulse.
- Long press (macro on): hold for 60 cycles → exactly one `BTN_LONG[0]` pulse, 16 edges after `BTN_DOWN[0]` rises. With the macro off, `BTN_LONG` stays 0.
- Reset mid-press: `RST` asserted while `BTN_DOWN[0]`=1 → 0 after the edge with no `BTN_RELEASE`. Keep the pin held and deassert `RST` → `BTN_PRESS[0]` fires 6 cycles after the first post-reset sampling edge.
